alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl_pkg.sv | 45 ++++
 rtl/regfile4x8.sv | 31 +++
 rtl/alu_ctrl.sv | 114 +++++++++++
 tb/tb_alu_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared opcode constants, legal-opcode decode and FSM state encoding for the alu_ctrl
// sequencer.
package alu_ctrl_pkg;

    localparam logic [3:0] OpNop   = 4'b0000;
    localparam logic [3:0] OpLdi   = 4'b0001;
    localparam logic [3:0] OpAddA  = 4'b0100;
    localparam logic [3:0] OpAddB  = 4'b1100;
    localparam logic [3:0] OpSubA  = 4'b0101;
    localparam logic [3:0] OpSubB  = 4'b1101;
    localparam logic [3:0] OpAndA  = 4'b0110;
    localparam logic [3:0] OpAndB  = 4'b1110;
    localparam logic [3:0] OpOrA   = 4'b1000;
    localparam logic [3:0] OpOrB   = 4'b1001;
    localparam logic [3:0] OpXorA  = 4'b1010;
    localparam logic [3:0] OpXorB  = 4'b1011;
    localparam logic [3:0] OpIll0  = 4'b0010;
    localparam logic [3:0] OpIll1  = 4'b0011;
    localparam logic [3:0] OpIll2  = 4'b0111;
    localparam logic [3:0] OpIll3  = 4'b1111;

    typedef enum logic [1:0] {StIdle, StImm, StExec, StWb} state_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        logic hit;
        hit = 1'b0;
        case (op)
            OpAddA, OpAddB, OpSubA, OpSubB, OpAndA, OpAndB,
            OpOrA, OpOrB, OpXorA, OpXorB: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic is_illegal_op(input logic [3:0] op);
        logic hit;
        hit = 1'b0;
        case (op)
            OpIll0, OpIll1, OpIll2, OpIll3: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/regfile4x8.sv
// Four-entry 8-bit register file: two combinational read ports, one synchronous write
// port, synchronous active-low reset.
module regfile4x8 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       we_i,
    input  logic [1:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [1:0] raddr_a_i,
    output logic [7:0] rdata_a_o,
    input  logic [1:0] raddr_b_i,
    output logic [7:0] rdata_b_o
);

    logic [7:0] regs_q [4];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see the pre-write value during a write cycle.
    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_ctrl.sv
// Byte-stream instruction sequencer driving an external combinational ALU and writing
// results back into a four-entry register file.
module alu_ctrl
    import alu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [7:0] instr_data,
    output logic       instr_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_result,
    output logic       result_valid,
    output logic [7:0] result_out,
    output logic       zero,
    output logic       illegal
);

    state_e     state_q, state_d;
    logic [3:0] op_q;
    logic [1:0] rd_q, rs_q;
    logic [7:0] res_q;
    logic       illegal_q;
    logic       accept;
    logic [3:0] opcode;
    logic [7:0] rdata_a, rdata_b;
    logic       rf_we;

    assign opcode = instr_data[7:4];
    assign accept = instr_valid && instr_ready;

    regfile4x8 u_regfile (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .we_i      (rf_we),
        .waddr_i   (rd_q),
        .wdata_i   (res_q),
        .raddr_a_i (rd_q),
        .rdata_a_o (rdata_a),
        .raddr_b_i (rs_q),
        .rdata_b_o (rdata_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (opcode == OpLdi) begin
                        state_d = StImm;
                    end else if (is_alu_op(opcode)) begin
                        state_d = StExec;
                    end
                end
            end
            StImm:   if (instr_valid) state_d = StWb;
            StExec:  state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        instr_ready  = (state_q == StIdle) || (state_q == StImm);
        result_valid = (state_q == StWb);
        rf_we        = (state_q == StWb);
        alu_a        = 8'h00;
        alu_b        = 8'h00;
        alu_op       = OpNop;
        if (state_q == StExec) begin
            alu_a  = rdata_a;
            alu_b  = rdata_b;
            alu_op = op_q;
        end
    end

    // res_q doubles as the visible result, so it holds between writeback strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= OpNop;
            rd_q      <= 2'd0;
            rs_q      <= 2'd0;
            res_q     <= 8'h00;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= (state_q == StIdle) && accept && is_illegal_op(opcode);
            if ((state_q == StIdle) && accept) begin
                op_q <= opcode;
                rd_q <= instr_data[3:2];
                rs_q <= instr_data[1:0];
            end
            if ((state_q == StImm) && instr_valid) begin
                res_q <= instr_data;
            end else if (state_q == StExec) begin
                res_q <= alu_result;
            end
        end
    end

    assign result_out = res_q;
    assign zero       = (res_q == 8'h00);
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: a behavioural ALU, a register model and a result scoreboard
// popped on each writeback strobe.
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic [7:0] instr_data = 8'h00;
    logic       instr_ready;
    logic [7:0] alu_a, alu_b, alu_result, result_out;
    logic [3:0] alu_op;
    logic       result_valid, zero, illegal;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] sb_q [$];
    logic [7:0] rf [4];
    logic [7:0] last_res;

    always #5 clk = ~clk;

    alu_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_data   (instr_data),
        .instr_ready  (instr_ready),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .result_valid (result_valid),
        .result_out   (result_out),
        .zero         (zero),
        .illegal      (illegal)
    );

    function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        case (op)
            4'b0100, 4'b1100: return a + b;
            4'b0101, 4'b1101: return a - b;
            4'b0110, 4'b1110: return a & b;
            4'b1000, 4'b1001: return a | b;
            4'b1010, 4'b1011: return a ^ b;
            default:          return 8'h00;
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_op, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] b);
        int n;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("ready_timeout", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr_data  = b;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic ldi(input logic [1:0] rd, input logic [7:0] val);
        accept({4'b0001, rd, 2'b00});
        chk("imm_ready", 32'(instr_ready), 32'd1);
        sb_q.push_back(val);
        rf[rd]   = val;
        last_res = val;
        accept(val);
        chk("ldi_rv", 32'(result_valid), 32'd1);
        tick();
        chk("ldi_idle_ready", 32'(instr_ready), 32'd1);
    endtask

    task automatic alu(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs);
        logic [7:0] exp;
        exp = alu_model(op, rf[rd], rf[rs]);
        sb_q.push_back(exp);
        accept({op, rd, rs});
        chk("exec_a", 32'(alu_a), 32'(rf[rd]));
        chk("exec_b", 32'(alu_b), 32'(rf[rs]));
        chk("exec_op", 32'(alu_op), 32'(op));
        chk("exec_ready", 32'(instr_ready), 32'd0);
        rf[rd]   = exp;
        last_res = exp;
        tick();
        chk("wb_rv", 32'(result_valid), 32'd1);
        chk("wb_ready", 32'(instr_ready), 32'd0);
        tick();
        chk("post_ready", 32'(instr_ready), 32'd1);
        chk("post_rv", 32'(result_valid), 32'd0);
        chk("post_alu_op", 32'(alu_op), 32'd0);
    endtask

    // Scoreboard: every writeback strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("rv_unexpected", 32'd1, 32'd0);
            end else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                chk("result_out", 32'(result_out), 32'(e));
                chk("zero", 32'(zero), 32'(e == 8'h00));
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
        last_res = 8'h00;

        rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_result_out", 32'(result_out), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_release_ready", 32'(instr_ready), 32'd1);

        // ADD after two loads
        ldi(2'd1, 8'h05);
        ldi(2'd2, 8'h03);
        alu(4'b0100, 2'd1, 2'd2);

        // SUB to zero, then wrap-around via alternate SUB encoding
        ldi(2'd1, 8'h03);
        alu(4'b0101, 2'd1, 2'd2);
        alu(4'b1101, 2'd1, 2'd2);

        // Remaining operations, alternate encodings, rd == rs and modulo-256 add
        ldi(2'd0, 8'hC6);
        alu(4'b1110, 2'd0, 2'd2);
        alu(4'b1001, 2'd0, 2'd1);
        alu(4'b1011, 2'd1, 2'd0);
        ldi(2'd2, 8'h90);
        alu(4'b1100, 2'd2, 2'd2);

        // NOP: no effect
        accept(8'h0F);
        chk("nop_ready", 32'(instr_ready), 32'd1);
        chk("nop_rv", 32'(result_valid), 32'd0);
        chk("nop_illegal", 32'(illegal), 32'd0);

        // Illegal opcode: one-cycle strobe, nothing else changes
        accept(8'h76);
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_ready", 32'(instr_ready), 32'd1);
        chk("ill_rv", 32'(result_valid), 32'd0);
        chk("ill_hold", 32'(result_out), 32'(last_res));
        tick();
        chk("ill_pulse_end", 32'(illegal), 32'd0);
        accept(8'hF0);
        chk("ill_f_pulse", 32'(illegal), 32'd1);
        tick();
        alu(4'b1000, 2'd1, 2'd2);

        // LDI with a long gap before the immediate
        accept({4'b0001, 2'd3, 2'b00});
        for (int i = 0; i < 10; i++) begin
            chk("imm_wait_ready", 32'(instr_ready), 32'd1);
            chk("imm_wait_rv", 32'(result_valid), 32'd0);
            tick();
        end
        sb_q.push_back(8'hAA);
        rf[3]    = 8'hAA;
        last_res = 8'hAA;
        accept(8'hAA);
        chk("imm_gap_rv", 32'(result_valid), 32'd1);
        tick();
        chk("hold_result", 32'(result_out), 32'hAA);

        // Reset during EXEC abandons the instruction and clears the register file
        accept({4'b1010, 2'd3, 2'd1});
        chk("xor_exec_op", 32'(alu_op), 32'(4'b1010));
        rst_n = 1'b0;
        tick();
        chk("exec_rst_rv", 32'(result_valid), 32'd0);
        chk("exec_rst_result", 32'(result_out), 32'd0);
        chk("exec_rst_zero", 32'(zero), 32'd1);
        chk("exec_rst_alu_op", 32'(alu_op), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("exec_rst_ready", 32'(instr_ready), 32'd1);
        chk("exec_rst_no_wb", 32'(result_valid), 32'd0);
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
        last_res = 8'h00;
        alu(4'b0100, 2'd3, 2'd1);
        alu(4'b1000, 2'd0, 2'd2);

        // Back-to-back: valid held high, one accept every 3 cycles
        ldi(2'd3, 8'h01);
        instr_valid = 1'b1;
        instr_data  = {4'b0100, 2'd3, 2'd3};
        for (int i = 0; i < 9; i++) begin
            chk("b2b_ready", 32'(instr_ready), 32'((i % 3) == 0));
            chk("b2b_rv", 32'(result_valid), 32'((i % 3) == 2));
            if ((i % 3) == 0) begin
                sb_q.push_back(rf[3] + rf[3]);
                rf[3] = rf[3] + rf[3];
            end
            tick();
        end
        instr_valid = 1'b0;
        chk("b2b_end_ready", 32'(instr_ready), 32'd1);

        repeat (3) tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
